hack_ram8: RTL and testbench
============================

Name: hack_ram8

Overview:
- Eight-word, 16-bit register file forming the Hack RAM8 stage.
- It sits directly downstream of the 1-to-8 demultiplexer: the one-hot load strobes that demux produces are consumed here as per-word write enables.
- Read data is selected back out through an 8-way multiplexer.
- Adds a sequential clear sweep, so higher RAM levels (RAM64, RAM512) can soft-clear memory without asserting reset.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 8, number of words; fixed at 8, the address is 3 bits wide.

Ports:
- clk_in  input  1  single clock; all state updates on its rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  write data.
- addr_in  input  3  word address for both read and write.
- load_in  input  1  write strobe; demuxed internally by addr_in into 8 one-hot loads.
- clear_in  input  1  request to start the clear sweep; a one-cycle pulse is sufficient.
- data_out  output  WIDTH  contents of word[addr_in].
- busy_out  output  1  high while the clear sweep runs.

Behaviour:
- Reset:
  - rst_in high clears all 8 words to 0, the FSM to IDLE and the sweep counter to 0 immediately, with no clock edge required.
  - busy_out=0 during and after reset.
  - data_out=0, since every word is 0.
- Interface (already decided): one clock, clk_in; reset rst_in is asynchronous and active-high.
- Read:
  - data_out = word[addr_in], combinational from stored state, 0-cycle latency from an addr_in change.
  - data_out does not depend on data_in (unless the optional bypass below is compiled in).
- Write:
  - Applies in IDLE with load_in=1.
  - At the rising edge, exactly word[addr_in] <= data_in; the other 7 words hold.
  - The new value is visible on data_out from the cycle after the edge; 1-cycle write latency.
- Load decode:
  - Exactly one of the 8 internal load lines is high when load_in=1; none when load_in=0.
  - addr 0 maps to word0 ... addr 7 maps to word7.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR: on a clock edge with clear_in=1. That edge loads sweep counter=0; no words are cleared at that edge. busy_out goes high the following cycle.
  - CLEAR: each edge writes word[counter] <= 0 and increments the counter. Word 0 is cleared on the first CLEAR edge, word 7 on the eighth. After the edge that clears word 7, return to IDLE.
  - busy_out=1 for exactly 8 cycles.
  - CLEAR -> IDLE: counter wraps 7 -> 0 on the return; busy_out=0 in the cycle after the last clear.
- Simultaneous events:
  - clear_in=1 and load_in=1 in the same IDLE cycle: the write of data_in to addr_in is performed at that edge and the sweep starts; that word is later cleared by the sweep.
  - load_in while busy_out=1: ignored, no word is written.
  - clear_in while busy_out=1: ignored; the sweep does not restart.
- Reads during the sweep are allowed. data_out reflects current state: words already cleared read 0, words not yet reached keep their old value.
- Reset mid-sweep: all words go to 0, FSM to IDLE and busy_out to 0 asynchronously. The sweep does not resume after reset release.
- No X propagation: all 8 words are defined from reset onward.

Optional Feature:
- Macro: HACK_RAM8_WRITE_BYPASS_EN.
- Defined:
  - In IDLE with load_in=1, data_out = data_in in the same cycle (write-through forwarding), since addr_in selects the word being written.
  - During CLEAR, or with load_in=0, read behaviour is unchanged.
- Undefined: data_out always shows stored contents; the written value appears the cycle after the edge.

Test Plan:
- Reset state: assert rst_in mid-cycle without a clock edge -> data_out=0x0000 for all addr_in 0..7; busy_out=0.
- Write/readback: write 0x1234 to addr 3, 0xBEEF to addr 7, 0xFFFF to addr 0 -> readback 0x1234, 0xBEEF, 0xFFFF at those addresses; the other 5 words read 0.
- One-hot decode: write 8 distinct values (addr*0x1111) to addr 0..7, then rewrite addr 5 with 0x0000 -> only addr 5 reads 0; all others are unchanged. The value written to addr 5 is not visible on data_out until the edge after the write; with HACK_RAM8_WRITE_BYPASS_EN it is visible in the same cycle.
- Clear sweep: fill with nonzero data, pulse clear_in 1 cycle -> busy_out high for exactly 8 cycles. Reading addr 4 each cycle shows old data until the 5th busy cycle edge, then 0. After the sweep, all words read 0.
- Write during busy: during CLEAR, load_in=1 to addr 2 with 0xAAAA -> ignored; addr 2 reads 0 after the sweep. A clear_in pulse at busy cycle 3 does not extend busy_out beyond 8 cycles.
- Reset mid-sweep: pulse clear_in, assert rst_in at busy cycle 4 -> busy_out=0 immediately, all words 0. After release, a write to addr 6 of 0x00C3 works normally and reads 0x00C3.

Source files
------------

// File: rtl/hack_ram8_if.sv
// Bus bundle for the Hack RAM8 stage: write data, address, strobes and read-back.
// The master drives requests; the RAM8 block sits on the slave side.
interface hack_ram8_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] data_in;
    logic [2:0]       addr_in;
    logic             load_in;
    logic             clear_in;
    logic [WIDTH-1:0] data_out;
    logic             busy_out;

    modport master (
        output data_in, addr_in, load_in, clear_in,
        input  data_out, busy_out
    );

    modport slave (
        input  data_in, addr_in, load_in, clear_in,
        output data_out, busy_out
    );
endinterface

// File: rtl/hack_ram8.sv
// Eight-word register file with one-hot load decode and a sequential clear sweep.
// Optional write-through forwarding is compiled in with HACK_RAM8_WRITE_BYPASS_EN.
module hack_ram8 #(
    parameter int WIDTH = 16
) (
    input  logic           clk_in,
    input  logic           rst_in,
    hack_ram8_if.slave     bus
);
    localparam int DEPTH = 8;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           state_q, state_d;
    logic [2:0]       sweepCnt_q, sweepCnt_d;
    logic [WIDTH-1:0] word_q [DEPTH];
    logic [DEPTH-1:0] loadVec;
    logic [DEPTH-1:0] clearVec;

    // State, sweep counter and storage; reset clears everything without a clock edge
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            sweepCnt_q <= 3'd0;
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            sweepCnt_q <= sweepCnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (clearVec[i]) begin
                    word_q[i] <= '0;
                end else if (loadVec[i]) begin
                    word_q[i] <= bus.data_in;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sweepCnt_d = sweepCnt_q;
        case (state_q)
            IDLE: begin
                if (bus.clear_in) begin
                    state_d    = CLEAR;
                    sweepCnt_d = 3'd0;
                end
            end
            CLEAR: begin
                sweepCnt_d = sweepCnt_q + 3'd1;
                if (sweepCnt_q == 3'd7) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Demux the strobe into one-hot loads; writes only land while idle
    always_comb begin
        loadVec  = '0;
        clearVec = '0;
        if (state_q == IDLE && bus.load_in) begin
            loadVec[bus.addr_in] = 1'b1;
        end
        if (state_q == CLEAR) begin
            clearVec[sweepCnt_q] = 1'b1;
        end
    end

    always_comb begin
        bus.busy_out = (state_q == CLEAR);
        bus.data_out = word_q[bus.addr_in];
`ifdef HACK_RAM8_WRITE_BYPASS_EN
        if (state_q == IDLE && bus.load_in) begin
            bus.data_out = bus.data_in;
        end
`endif
    end
endmodule

// File: tb/tb_hack_ram8.sv
// Self-checking bench for hack_ram8: directed table, corner sequences and random traffic vs. a word-array model.
module tb_hack_ram8;
    logic clk;
    logic rst;

    hack_ram8_if #(.WIDTH(16)) bus ();

    hack_ram8 #(.WIDTH(16)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectorCount = 0;
    int missCount   = 0;

    logic [15:0] modelMem [8];
    int          busyLeft;

    typedef struct {
        logic        load;
        logic [2:0]  addr;
        logic [15:0] data;
        logic [15:0] expRead;
    } vec_t;

    vec_t table1 [11];

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectorCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 8; i++) modelMem[i] = 16'h0000;
        busyLeft = 0;
    endtask

    // Model one rising edge from the inputs currently on the bus
    task automatic modelEdge();
        if (busyLeft > 0) begin
            modelMem[8 - busyLeft] = 16'h0000;
            busyLeft--;
        end else begin
            if (bus.load_in) modelMem[bus.addr_in] = bus.data_in;
            if (bus.clear_in) busyLeft = 8;
        end
    endtask

    function automatic logic [15:0] expRead();
        logic [15:0] v;
        v = modelMem[bus.addr_in];
`ifdef HACK_RAM8_WRITE_BYPASS_EN
        if (bus.load_in && busyLeft == 0) v = bus.data_in;
`endif
        return v;
    endfunction

    task automatic applyStimulus(input logic load, input logic clear, input logic [2:0] addr, input logic [15:0] data);
        bus.load_in  = load;
        bus.clear_in = clear;
        bus.addr_in  = addr;
        bus.data_in  = data;
    endtask

    task automatic tick();
        modelEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllModel(input string name);
        applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000);
        for (int a = 0; a < 8; a++) begin
            bus.addr_in = 3'(a);
            #1;
            checkOutput(name, bus.data_out, modelMem[a]);
        end
    endtask

    task automatic fillRandom();
        for (int a = 0; a < 8; a++) begin
            applyStimulus(1'b1, 1'b0, 3'(a), 16'($urandom_range(1, 16'hFFFF)));
            tick();
        end
        applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000);
    endtask

    initial begin
        int busyCycles;
        logic [15:0] v;

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000);
        modelReset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset asserted between edges must clear stored data at once
        fillRandom();
        #3 rst = 1'b1;
        modelReset();
        #1;
        checkOutput("reset_busy", {15'd0, bus.busy_out}, 16'h0000);
        for (int a = 0; a < 8; a++) begin
            bus.addr_in = 3'(a);
            #0.5;
            checkOutput("reset_word", bus.data_out, 16'h0000);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed write/readback table
        table1[0]  = '{1'b1, 3'd3, 16'h1234, 16'h0000};
        table1[1]  = '{1'b1, 3'd7, 16'hBEEF, 16'h0000};
        table1[2]  = '{1'b1, 3'd0, 16'hFFFF, 16'h0000};
        table1[3]  = '{1'b0, 3'd3, 16'h5555, 16'h1234};
        table1[4]  = '{1'b0, 3'd7, 16'h5555, 16'hBEEF};
        table1[5]  = '{1'b0, 3'd0, 16'h5555, 16'hFFFF};
        table1[6]  = '{1'b0, 3'd1, 16'h5555, 16'h0000};
        table1[7]  = '{1'b0, 3'd2, 16'h5555, 16'h0000};
        table1[8]  = '{1'b0, 3'd4, 16'h5555, 16'h0000};
        table1[9]  = '{1'b0, 3'd5, 16'h5555, 16'h0000};
        table1[10] = '{1'b0, 3'd6, 16'h5555, 16'h0000};
        for (int i = 0; i < 11; i++) begin
            applyStimulus(table1[i].load, 1'b0, table1[i].addr, table1[i].data);
            #1;
            v = table1[i].expRead;
`ifdef HACK_RAM8_WRITE_BYPASS_EN
            if (table1[i].load) v = table1[i].data;
`endif
            checkOutput("table_read", bus.data_out, v);
            tick();
        end

        // One-hot decode: distinct pattern, then rewrite word 5 only
        for (int a = 0; a < 8; a++) begin
            applyStimulus(1'b1, 1'b0, 3'(a), 16'(a * 16'h1111));
            tick();
        end
        applyStimulus(1'b1, 1'b0, 3'd5, 16'h0000);
        #1;
`ifdef HACK_RAM8_WRITE_BYPASS_EN
        checkOutput("w5_same_cycle", bus.data_out, 16'h0000);
`else
        checkOutput("w5_same_cycle", bus.data_out, 16'h5555);
`endif
        tick();
        applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000);
        for (int a = 0; a < 8; a++) begin
            bus.addr_in = 3'(a);
            #1;
            checkOutput("onehot_word", bus.data_out, (a == 5) ? 16'h0000 : 16'(a * 16'h1111));
        end

        // Clear sweep: word 4 holds until the fifth sweep edge
        applyStimulus(1'b1, 1'b0, 3'd5, 16'h5A5A);
        tick();
        applyStimulus(1'b0, 1'b1, 3'd4, 16'h0000);
        #1;
        checkOutput("busy_at_start", {15'd0, bus.busy_out}, 16'h0000);
        tick();
        bus.clear_in = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            checkOutput("sweep_busy", {15'd0, bus.busy_out}, 16'h0001);
            checkOutput("sweep_word4", bus.data_out, (k <= 5) ? 16'h4444 : 16'h0000);
            tick();
        end
        checkOutput("sweep_done_busy", {15'd0, bus.busy_out}, 16'h0000);
        for (int a = 0; a < 8; a++) begin
            bus.addr_in = 3'(a);
            #1;
            checkOutput("sweep_cleared", bus.data_out, 16'h0000);
        end

        // Load and clear requests are ignored while busy
        fillRandom();
        applyStimulus(1'b0, 1'b1, 3'd0, 16'h0000);
        tick();
        busyCycles = 0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(busyCycles == 1, busyCycles == 2, 3'd2, 16'hAAAA);
            #1;
            if (bus.busy_out) busyCycles++;
            tick();
        end
        checkOutput("busy_len", 16'(busyCycles), 16'd8);
        checkAllModel("busy_ignore");
        bus.addr_in = 3'd2;
        #1;
        checkOutput("busy_addr2", bus.data_out, 16'h0000);

        // Reset in the middle of a sweep
        fillRandom();
        applyStimulus(1'b0, 1'b1, 3'd0, 16'h0000);
        tick();
        bus.clear_in = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b1;
        modelReset();
        #1;
        checkOutput("midrst_busy", {15'd0, bus.busy_out}, 16'h0000);
        checkAllModel("midrst_word");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) tick();
        checkOutput("midrst_no_resume", {15'd0, bus.busy_out}, 16'h0000);
        applyStimulus(1'b1, 1'b0, 3'd6, 16'h00C3);
        tick();
        applyStimulus(1'b0, 1'b0, 3'd6, 16'h0000);
        #1;
        checkOutput("midrst_write6", bus.data_out, 16'h00C3);

        // Random traffic against the word-array model
        for (int c = 0; c < 400; c++) begin
            applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                          3'($urandom_range(0, 7)), 16'($urandom));
            #1;
            checkOutput("rand_read", bus.data_out, expRead());
            checkOutput("rand_busy", {15'd0, bus.busy_out}, {15'd0, busyLeft > 0});
            tick();
        end
        checkAllModel("rand_final");

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule
